// File: rtl/mem_loader.sv
// Byte-stream program loader: unpacks a little-endian word count, N data words
// and an XOR checksum, writes the words to RAM and releases the core on success.
module mem_loader #(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ram_w_enable,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic        core_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {HDR, DATA, WRITE, CHK, DONE, ERR} state_e;

  localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

  state_e           state_q, state_d;
  logic [1:0]       bidx_q, bidx_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [ADDR_W:0]  widx_q, widx_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [31:0]      asm_q, asm_d;
  logic             wen_q, wen_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             accept;

  assign in_ready     = (state_q == HDR) || (state_q == DATA) || (state_q == CHK);
  assign accept       = in_valid && in_ready;
  assign ram_w_enable = wen_q;
  assign ram_w_addr   = waddr_q;
  assign ram_w_data   = wdata_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign core_hold    = (state_q != DONE);

  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    cksum_d = cksum_q;
    asm_d   = asm_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      HDR: begin
        if (accept) begin
          cnt_d   = {in_data, cnt_q[31:8]};
          cksum_d = cksum_q ^ in_data;
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            if ({1'b0, cnt_d} > MAX_WORDS) state_d = ERR;
            else if (cnt_d == '0)         state_d = CHK;
            else                          state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_d   = {in_data, asm_q[31:8]};
          cksum_d = cksum_q ^ in_data;
          bidx_d  = bidx_q + 2'd1;
          // Write address/data are registered here so they are valid during WRITE.
          if (bidx_q == 2'd3) begin
            state_d = WRITE;
            wen_d   = 1'b1;
            waddr_d = BASE_ADDR + (32'(widx_q) << 2);
            wdata_d = asm_d;
          end
        end
      end
      WRITE: begin
        widx_d  = widx_q + (ADDR_W + 1)'(1);
        state_d = ((32'(widx_q) + 32'd1) < cnt_q) ? DATA : CHK;
      end
      CHK: begin
        if (accept) state_d = (in_data == cksum_q) ? DONE : ERR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HDR;
      bidx_q  <= '0;
      cnt_q   <= '0;
      widx_q  <= '0;
      cksum_q <= '0;
      asm_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      cksum_q <= cksum_d;
      asm_q   <= asm_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream program loader for the RISC-V core.
- Receives a byte stream (host/UART side) carrying a word count, program words and a checksum. Writes the words into the core's unified RAM through its write port.
- Holds the core in reset until loading completes, replacing bench-side memory preloading with a synthesizable path.

Parameters:
- ADDR_W, 14, RAM word-address width; capacity is 2**ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first loaded word; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data.
- in_ready  output  1  loader accepts a byte when in_valid && in_ready at a rising edge.
- ram_w_enable  output  1  one-cycle RAM write strobe.
- ram_w_addr  output  32  RAM byte address of the write.
- ram_w_data  output  32  RAM write data.
- core_hold  output  1  high keeps the core in reset.
- done  output  1  load finished with a good checksum; sticky.
- err  output  1  load failed (oversize count or bad checksum); sticky.

Behaviour:
- Reset (reset low, asynchronous):
  - state=HDR, byte index=0, word count=0, word index=0, checksum=0.
  - in_ready=1, ram_w_enable=0, ram_w_addr=0, ram_w_data=0, core_hold=1, done=0, err=0.
- Stream format, all multi-byte fields little-endian:
  - 4-byte word count N.
  - N words of 4 bytes each.
  - 1 checksum byte equal to the XOR of every preceding byte (header and data).
- States: HDR, DATA, WRITE, CHK, DONE, ERR.
- HDR:
  - Accept 4 bytes into the N register, LSB first; each accepted byte is XORed into the checksum.
  - After the 4th byte:
    - N > 2**ADDR_W -> ERR.
    - N == 0 -> CHK.
    - Otherwise -> DATA.
- DATA:
  - Accept 4 bytes into the assembly register, LSB first, XORing each into the checksum.
  - On the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - in_ready=0; ram_w_enable=1.
  - ram_w_addr = BASE_ADDR + 4*word_index, 32-bit wrap.
  - ram_w_data = assembled word.
  - word_index increments.
  - Next state: DATA if word_index+1 < N, otherwise CHK.
  - ram_w_addr and ram_w_data hold their last values after the strobe; ram_w_enable deasserts the cycle after WRITE.
- CHK:
  - Accept 1 byte.
  - Byte equal to the accumulated checksum -> DONE; otherwise -> ERR.
- DONE:
  - done=1, core_hold=0, in_ready=0.
  - Terminal until reset.
- ERR:
  - err=1, core_hold=1, in_ready=0.
  - Terminal until reset.
- in_ready is combinational from state only: high in HDR, DATA and CHK; low in WRITE, DONE and ERR.
- Stall tolerance: cycles with in_valid=0 cause no state change; any number of idle cycles between bytes is legal.
- done and err are never both 1.
- core_hold falls in the same cycle done rises, i.e. the cycle after the checksum byte is accepted.
- Reset mid-operation:
  - All progress is discarded and core_hold reasserts immediately (asynchronously).
  - Partially written RAM contents are not scrubbed.
- Latency: the write strobe occurs exactly 1 cycle after acceptance of a word's 4th byte.
- Throughput: at most 1 word per 5 cycles.

Test Plan:
- Header 01 00 00 00, data 13 00 00 00, checksum 0x12, in_valid held high:
  - Exactly one write: ram_w_addr=0x0, ram_w_data=0x00000013.
  - done=1 and core_hold=0 one cycle after the checksum byte.
  - in_ready low during the WRITE cycle.
- N=3, words 0x11223344, 0xAABBCCDD, 0x00000001, BASE_ADDR=0x100, correct checksum:
  - Writes at 0x100, 0x104, 0x108 with those data values, in order; done=1.
- Same as the previous case but checksum XORed with 0x01:
  - All 3 writes still occur; err=1, done=0, core_hold stays 1.
- ADDR_W=4, header 11 00 00 00 (N=17):
  - err=1 right after the 4th header byte; no ram_w_enable pulses; in_ready=0 thereafter.
- Header 00 00 00 00, checksum 0x00:
  - No writes; done=1.
- N=2 stream with random 0-3 cycle in_valid gaps, reset pulled low between the first and second word writes, then the full stream resent:
  - Outputs return to reset values immediately on reset assertion.
  - Second load rewrites from BASE_ADDR and ends with done=1.
